// File: rtl/wr_txn_ctrl.sv
// Single-outstanding AXI write sequencer: locks W/B to the slave decoded at AW, counts beats, returns B.
// Optional build macro WR_LAST_CHECK_EN: internal WLAST generation plus sticky WLAST-mismatch flag.
module wr_txn_ctrl #(
  parameter logic [31:0] S0_BASE = 32'h0000_0000,
  parameter logic [31:0] S1_BASE = 32'h0001_0000,
  parameter int unsigned LEN_W   = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             aw_fire,
  input  logic [31:0]      aw_addr,
  input  logic [LEN_W-1:0] aw_len,
  output logic             aw_allow,
  input  logic [31:0]      WDATA_M1,
  input  logic [3:0]       WSTRB_M1,
  input  logic             WLAST_M1,
  input  logic             WVALID_M1,
  output logic             WREADY_M1,
  output logic [31:0]      WDATA_S,
  output logic [3:0]       WSTRB_S,
  output logic             WLAST_S,
  output logic             WVALID_S0,
  output logic             WVALID_S1,
  output logic             WVALID_SDEFAULT,
  input  logic             WREADY_S0,
  input  logic             WREADY_S1,
  input  logic             WREADY_SDEFAULT,
  input  logic [7:0]       BID_S0,
  input  logic [7:0]       BID_S1,
  input  logic [7:0]       BID_SDEFAULT,
  input  logic [1:0]       BRESP_S0,
  input  logic [1:0]       BRESP_S1,
  input  logic [1:0]       BRESP_SDEFAULT,
  input  logic             BVALID_S0,
  input  logic             BVALID_S1,
  input  logic             BVALID_SDEFAULT,
  output logic             BREADY_S0,
  output logic             BREADY_S1,
  output logic             BREADY_SDEFAULT,
  output logic [3:0]       BID_M1,
  output logic [1:0]       BRESP_M1,
  output logic             BVALID_M1,
  input  logic             BREADY_M1,
  output logic             wlast_err
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DATA = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    SEL_NONE = 2'd0,
    SEL_S0   = 2'd1,
    SEL_S1   = 2'd2,
    SEL_SD   = 2'd3
  } sel_t;

  state_t           state_q, state_d;
  sel_t             sel_q, sel_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [LEN_W-1:0] beat_cnt_q, beat_cnt_d;

  logic       wready_sel;
  logic       bvalid_sel;
  logic [7:0] bid_sel;
  logic [1:0] bresp_sel;
  logic       beat;
  logic       last_beat;
  logic       b_hs;

  // Each window is 64 KiB; widened compare keeps a base near the top of the map from wrapping.
  function automatic sel_t decode(input logic [31:0] addr);
    logic [32:0] a;
    a = {1'b0, addr};
    if (a >= {1'b0, S0_BASE} && a <= ({1'b0, S0_BASE} + 33'h0_FFFF))
      return SEL_S0;
    else if (a >= {1'b0, S1_BASE} && a <= ({1'b0, S1_BASE} + 33'h0_FFFF))
      return SEL_S1;
    else
      return SEL_SD;
  endfunction

  always_comb begin
    wready_sel = 1'b0;
    bvalid_sel = 1'b0;
    bid_sel    = '0;
    bresp_sel  = '0;
    case (sel_q)
      SEL_S0: begin
        wready_sel = WREADY_S0;
        bvalid_sel = BVALID_S0;
        bid_sel    = BID_S0;
        bresp_sel  = BRESP_S0;
      end
      SEL_S1: begin
        wready_sel = WREADY_S1;
        bvalid_sel = BVALID_S1;
        bid_sel    = BID_S1;
        bresp_sel  = BRESP_S1;
      end
      SEL_SD: begin
        wready_sel = WREADY_SDEFAULT;
        bvalid_sel = BVALID_SDEFAULT;
        bid_sel    = BID_SDEFAULT;
        bresp_sel  = BRESP_SDEFAULT;
      end
      default: ;
    endcase
  end

  // Outputs are gated by rst so a mid-burst reset closes the channels in the same cycle.
  always_comb begin
    aw_allow        = 1'b0;
    WREADY_M1       = 1'b0;
    WVALID_S0       = 1'b0;
    WVALID_S1       = 1'b0;
    WVALID_SDEFAULT = 1'b0;
    BREADY_S0       = 1'b0;
    BREADY_S1       = 1'b0;
    BREADY_SDEFAULT = 1'b0;
    BVALID_M1       = 1'b0;
    BID_M1          = '0;
    BRESP_M1        = '0;
    if (!rst) begin
      case (state_q)
        ST_IDLE: aw_allow = 1'b1;
        ST_DATA: begin
          WREADY_M1       = wready_sel;
          WVALID_S0       = WVALID_M1 & (sel_q == SEL_S0);
          WVALID_S1       = WVALID_M1 & (sel_q == SEL_S1);
          WVALID_SDEFAULT = WVALID_M1 & (sel_q == SEL_SD);
        end
        ST_RESP: begin
          BVALID_M1       = bvalid_sel;
          BID_M1          = bid_sel[3:0];
          BRESP_M1        = bresp_sel;
          BREADY_S0       = BREADY_M1 & (sel_q == SEL_S0);
          BREADY_S1       = BREADY_M1 & (sel_q == SEL_S1);
          BREADY_SDEFAULT = BREADY_M1 & (sel_q == SEL_SD);
        end
        default: ;
      endcase
    end
  end

  assign WDATA_S   = WDATA_M1;
  assign WSTRB_S   = WSTRB_M1;
  assign beat      = WVALID_M1 & WREADY_M1;
  assign last_beat = (beat_cnt_q == len_q);
  assign b_hs      = BVALID_M1 & BREADY_M1;

  logic [3:0] bid_hi_unused;
  assign bid_hi_unused = BID_S0[7:4] ^ BID_S1[7:4] ^ BID_SDEFAULT[7:4];

  always_comb begin
    state_d    = state_q;
    sel_d      = sel_q;
    len_d      = len_q;
    beat_cnt_d = beat_cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (aw_fire) begin
          sel_d      = decode(aw_addr);
          len_d      = aw_len;
          beat_cnt_d = '0;
          state_d    = ST_DATA;
        end
      end
      ST_DATA: begin
        if (beat) begin
          beat_cnt_d = beat_cnt_q + 1'b1;
          if (last_beat) state_d = ST_RESP;
        end
      end
      ST_RESP: begin
        if (b_hs) begin
          state_d = ST_IDLE;
          sel_d   = SEL_NONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        sel_d   = SEL_NONE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      sel_q      <= SEL_NONE;
      len_q      <= '0;
      beat_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      sel_q      <= sel_d;
      len_q      <= len_d;
      beat_cnt_q <= beat_cnt_d;
    end
  end

`ifdef WR_LAST_CHECK_EN
  logic wlast_err_q, wlast_err_d;

  assign WLAST_S = last_beat;

  always_comb begin
    wlast_err_d = wlast_err_q;
    if (beat && (WLAST_M1 != last_beat)) wlast_err_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) wlast_err_q <= 1'b0;
    else     wlast_err_q <= wlast_err_d;
  end

  assign wlast_err = wlast_err_q;
`else
  assign WLAST_S   = WLAST_M1;
  assign wlast_err = 1'b0;
`endif

endmodule

// File: tb/tb_wr_txn_ctrl.sv
// Directed bench for wr_txn_ctrl: decode, beat counting, B routing, throttling, reset and WLAST handling.
module tb_wr_txn_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        aw_fire;
  logic [31:0] aw_addr;
  logic [3:0]  aw_len;
  logic        aw_allow;
  logic [31:0] WDATA_M1;
  logic [3:0]  WSTRB_M1;
  logic        WLAST_M1, WVALID_M1, WREADY_M1;
  logic [31:0] WDATA_S;
  logic [3:0]  WSTRB_S;
  logic        WLAST_S;
  logic        WVALID_S0, WVALID_S1, WVALID_SDEFAULT;
  logic        WREADY_S0, WREADY_S1, WREADY_SDEFAULT;
  logic [7:0]  BID_S0, BID_S1, BID_SDEFAULT;
  logic [1:0]  BRESP_S0, BRESP_S1, BRESP_SDEFAULT;
  logic        BVALID_S0, BVALID_S1, BVALID_SDEFAULT;
  logic        BREADY_S0, BREADY_S1, BREADY_SDEFAULT;
  logic [3:0]  BID_M1;
  logic [1:0]  BRESP_M1;
  logic        BVALID_M1, BREADY_M1;
  logic        wlast_err;

  int unsigned vectors = 0;
  int unsigned miscompares = 0;

  always #5 clk = ~clk;

  wr_txn_ctrl #(
    .S0_BASE(32'h0000_0000),
    .S1_BASE(32'h0001_0000),
    .LEN_W  (4)
  ) dut (
    .clk(clk), .rst(rst),
    .aw_fire(aw_fire), .aw_addr(aw_addr), .aw_len(aw_len), .aw_allow(aw_allow),
    .WDATA_M1(WDATA_M1), .WSTRB_M1(WSTRB_M1), .WLAST_M1(WLAST_M1),
    .WVALID_M1(WVALID_M1), .WREADY_M1(WREADY_M1),
    .WDATA_S(WDATA_S), .WSTRB_S(WSTRB_S), .WLAST_S(WLAST_S),
    .WVALID_S0(WVALID_S0), .WVALID_S1(WVALID_S1), .WVALID_SDEFAULT(WVALID_SDEFAULT),
    .WREADY_S0(WREADY_S0), .WREADY_S1(WREADY_S1), .WREADY_SDEFAULT(WREADY_SDEFAULT),
    .BID_S0(BID_S0), .BID_S1(BID_S1), .BID_SDEFAULT(BID_SDEFAULT),
    .BRESP_S0(BRESP_S0), .BRESP_S1(BRESP_S1), .BRESP_SDEFAULT(BRESP_SDEFAULT),
    .BVALID_S0(BVALID_S0), .BVALID_S1(BVALID_S1), .BVALID_SDEFAULT(BVALID_SDEFAULT),
    .BREADY_S0(BREADY_S0), .BREADY_S1(BREADY_S1), .BREADY_SDEFAULT(BREADY_SDEFAULT),
    .BID_M1(BID_M1), .BRESP_M1(BRESP_M1), .BVALID_M1(BVALID_M1), .BREADY_M1(BREADY_M1),
    .wlast_err(wlast_err)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Inputs change 1ns after the rising edge; checks follow 1ns later, well before the next edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic clear_inputs();
    aw_fire = 0; aw_addr = '0; aw_len = '0;
    WDATA_M1 = '0; WSTRB_M1 = '0; WLAST_M1 = 0; WVALID_M1 = 0;
    WREADY_S0 = 0; WREADY_S1 = 0; WREADY_SDEFAULT = 0;
    BID_S0 = '0; BID_S1 = '0; BID_SDEFAULT = '0;
    BRESP_S0 = '0; BRESP_S1 = '0; BRESP_SDEFAULT = '0;
    BVALID_S0 = 0; BVALID_S1 = 0; BVALID_SDEFAULT = 0;
    BREADY_M1 = 0;
  endtask

  initial begin
    int unsigned beats;
    logic exp_wlast_s;
    clear_inputs();

    // 1: reset holds everything closed, even with master/slave handshakes offered
    rst = 1;
    WVALID_M1 = 1; WREADY_S0 = 1; WREADY_S1 = 1; BVALID_S0 = 1; BREADY_M1 = 1;
    tick();
    tick();
    check("rst_aw_allow", aw_allow, 0);
    check("rst_wready_m1", WREADY_M1, 0);
    check("rst_wvalid_s", {WVALID_S0, WVALID_S1, WVALID_SDEFAULT}, 0);
    check("rst_bready_s", {BREADY_S0, BREADY_S1, BREADY_SDEFAULT}, 0);
    check("rst_bvalid_m1", BVALID_M1, 0);
    check("rst_wlast_err", wlast_err, 0);
    clear_inputs();
    rst = 0;
    settle();
    check("post_rst_aw_allow", aw_allow, 1);
    check("idle_wready_closed", WREADY_M1, 0);

    // 2: S1 burst of 4 beats, slave ready every other cycle
    aw_fire = 1; aw_addr = 32'h0001_0010; aw_len = 4'd3;
    tick();
    aw_fire = 0;
    WVALID_M1 = 1; WDATA_M1 = 32'hCAFE_0001; WSTRB_M1 = 4'hA; WREADY_S0 = 1; WREADY_SDEFAULT = 1;
    beats = 0;
    for (int c = 0; c < 8; c++) begin
      WREADY_S1 = (c % 2 == 1);
      WLAST_M1 = (c == 7);
      settle();
      check("t2_aw_allow_busy", aw_allow, 0);
      check("t2_wvalid_s1", WVALID_S1, 1);
      check("t2_wvalid_others", {WVALID_S0, WVALID_SDEFAULT}, 0);
      check("t2_wready_m1", WREADY_M1, (c % 2 == 1));
`ifdef WR_LAST_CHECK_EN
      exp_wlast_s = (c >= 6);
`else
      exp_wlast_s = (c == 7);
`endif
      check("t2_wlast_s", WLAST_S, exp_wlast_s);
      if (c == 7) begin
        check("t2_wdata_s", WDATA_S, 32'hCAFE_0001);
        check("t2_wstrb_s", WSTRB_S, 4'hA);
      end
      tick();
    end
    WLAST_M1 = 0; WREADY_S1 = 0;
    BVALID_S1 = 1; BID_S1 = 8'h31; BRESP_S1 = 2'b10; BREADY_M1 = 1;
    BVALID_S0 = 1; BID_S0 = 8'hA7;
    settle();
    check("t2_resp_wvalid_s1", WVALID_S1, 0);
    check("t2_resp_wready_m1", WREADY_M1, 0);
    check("t2_bvalid_m1", BVALID_M1, 1);
    check("t2_bid_m1", BID_M1, 4'h1);
    check("t2_bresp_m1", BRESP_M1, 2'b10);
    check("t2_bready_s1", BREADY_S1, 1);
    check("t2_bready_s0", BREADY_S0, 0);
    tick();
    clear_inputs();
    settle();
    check("t2_idle_aw_allow", aw_allow, 1);
    check("t2_idle_bvalid_m1", BVALID_M1, 0);
    check("t2_idle_bid_m1", BID_M1, 0);

    // 3: S0 single beat; master stalls B for 3 cycles
    aw_fire = 1; aw_addr = 32'h0000_0004; aw_len = 4'd0;
    tick();
    aw_fire = 0;
    WVALID_M1 = 1; WREADY_S0 = 1; WLAST_M1 = 1;
    settle();
    check("t3_wvalid_s0", WVALID_S0, 1);
    check("t3_wready_m1", WREADY_M1, 1);
    tick();
    clear_inputs();
    BVALID_S0 = 1; BRESP_S0 = 2'b01; BID_S0 = 8'h0C;
    for (int c = 0; c < 3; c++) begin
      settle();
      check("t3_bvalid_held", BVALID_M1, 1);
      check("t3_bready_s0_low", BREADY_S0, 0);
      check("t3_aw_allow_low", aw_allow, 0);
      tick();
    end
    BREADY_M1 = 1;
    aw_fire = 1; aw_addr = 32'h0001_0000;
    settle();
    check("t3_bready_s0", BREADY_S0, 1);
    check("t3_bid_m1", BID_M1, 4'hC);
    check("t3_aw_allow_hs", aw_allow, 0);
    tick();
    clear_inputs();
    settle();
    check("t3_aw_allow_after", aw_allow, 1);
    check("t3_fire_ignored_idle", WREADY_M1, 0);

    // 4: unmapped address goes to SDEFAULT; spurious S0 response is ignored
    aw_fire = 1; aw_addr = 32'h0002_0000; aw_len = 4'd0;
    tick();
    aw_fire = 0;
    WVALID_M1 = 1; WREADY_SDEFAULT = 1; WREADY_S0 = 0; WLAST_M1 = 1;
    settle();
    check("t4_wvalid_sd", WVALID_SDEFAULT, 1);
    check("t4_wvalid_s0", WVALID_S0, 0);
    check("t4_wready_m1", WREADY_M1, 1);
    tick();
    clear_inputs();
    BVALID_S0 = 1; BID_S0 = 8'hA0; BREADY_M1 = 1;
    settle();
    check("t4_bready_s0", BREADY_S0, 0);
    check("t4_bvalid_m1_spurious", BVALID_M1, 0);
    check("t4_bready_sd", BREADY_SDEFAULT, 1);
    tick();
    BVALID_SDEFAULT = 1; BID_SDEFAULT = 8'h5E; BRESP_SDEFAULT = 2'b11;
    settle();
    check("t4_bvalid_m1", BVALID_M1, 1);
    check("t4_bid_m1", BID_M1, 4'hE);
    check("t4_bresp_m1", BRESP_M1, 2'b11);
    tick();
    clear_inputs();
    settle();
    check("t4_aw_allow", aw_allow, 1);

    // 5: reset after 2 of 4 beats
    aw_fire = 1; aw_addr = 32'h0000_8000; aw_len = 4'd3;
    tick();
    aw_fire = 0;
    WVALID_M1 = 1; WREADY_S0 = 1;
    for (int c = 0; c < 2; c++) begin
      settle();
      check("t5_wready_m1", WREADY_M1, 1);
      tick();
    end
    rst = 1;
    settle();
    check("t5_rst_wready_m1", WREADY_M1, 0);
    check("t5_rst_wvalid_s0", WVALID_S0, 0);
    check("t5_rst_aw_allow", aw_allow, 0);
    tick();
    rst = 0;
    settle();
    check("t5_after_aw_allow", aw_allow, 1);
    check("t5_after_wready_m1", WREADY_M1, 0);
    check("t5_after_wvalid_s0", WVALID_S0, 0);
    clear_inputs();

    // 6: len=1 with WLAST_M1 asserted early
    aw_fire = 1; aw_addr = 32'h0001_FFFC; aw_len = 4'd1;
    tick();
    aw_fire = 0;
    WVALID_M1 = 1; WREADY_S1 = 1; WLAST_M1 = 1;
    settle();
`ifdef WR_LAST_CHECK_EN
    check("t6_wlast_s_beat1", WLAST_S, 0);
`else
    check("t6_wlast_s_beat1", WLAST_S, 1);
`endif
    check("t6_err_before", wlast_err, 0);
    tick();
    settle();
`ifdef WR_LAST_CHECK_EN
    check("t6_err_set", wlast_err, 1);
`else
    check("t6_err_tied", wlast_err, 0);
`endif
    check("t6_wlast_s_beat2", WLAST_S, 1);
    check("t6_wvalid_s1_beat2", WVALID_S1, 1);
    tick();
    clear_inputs();
    BVALID_S1 = 1; BREADY_M1 = 1;
    settle();
    check("t6_resp_bvalid", BVALID_M1, 1);
    tick();
    clear_inputs();
    settle();
`ifdef WR_LAST_CHECK_EN
    check("t6_err_sticky", wlast_err, 1);
`else
    check("t6_err_sticky", wlast_err, 0);
`endif
    check("t6_idle_aw_allow", aw_allow, 1);
    rst = 1;
    tick();
    rst = 0;
    settle();
    check("t6_err_cleared", wlast_err, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "bench time limit exceeded");
  end

endmodule
